// File: rtl/instruction_memory_loader_pkg.sv
// Shared state encodings, widths and output decode for the instruction memory loader.
// Defining IMEM_LOADER_CHECKSUM_EN adds the CHECK state for the XOR checksum trailer.
package instruction_memory_loader_pkg;

    localparam int unsigned BYTE_WIDTH      = 8;
    localparam int unsigned WORD_WIDTH      = 32;
    localparam int unsigned LEN_WIDTH       = 16;
    localparam int unsigned LDR_STATE_WIDTH = 3;

    typedef enum logic [LDR_STATE_WIDTH-1:0] {
        LDR_IDLE   = 3'd0,
        LDR_LEN_LO = 3'd1,
        LDR_LEN_HI = 3'd2,
        LDR_DATA   = 3'd3,
        LDR_WRITE  = 3'd4,
`ifdef IMEM_LOADER_CHECKSUM_EN
        LDR_CHECK  = 3'd5,
`endif
        LDR_DONE   = 3'd6,
        LDR_ERR    = 3'd7
    } ldr_state_e;

    typedef struct packed {
        logic rx_ready;
        logic wr_en;
        logic cpu_hold;
        logic busy;
        logic done;
        logic error;
    } ldr_ctl_t;

    // Moore decode of the control outputs; done/error are sticky because only start leaves DONE/ERR.
    function automatic ldr_ctl_t ldr_decode(input ldr_state_e s);
        ldr_ctl_t c;
        c          = '0;
        c.cpu_hold = (s != LDR_DONE);
        c.done     = (s == LDR_DONE);
        c.error    = (s == LDR_ERR);
        c.wr_en    = (s == LDR_WRITE);
        case (s)
            LDR_LEN_LO, LDR_LEN_HI, LDR_DATA: begin
                c.rx_ready = 1'b1;
                c.busy     = 1'b1;
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            LDR_CHECK: begin
                c.rx_ready = 1'b1;
                c.busy     = 1'b1;
            end
`endif
            LDR_WRITE: c.busy = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/instruction_memory_loader_word_assembler.sv
// Little-endian word assembler: bytes shift in from the top so the first byte ends up as the LSB.
module instruction_memory_loader_word_assembler
    import instruction_memory_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  load_en,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_full_c
);

    logic [1:0] byte_idx;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            word     <= '0;
            byte_idx <= '0;
        end else if (load_en) begin
            word     <= {byte_in, word[WORD_WIDTH-1:BYTE_WIDTH]};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    // High while the next accepted byte completes the word.
    assign word_full_c = (byte_idx == 2'd3);

endmodule

// File: rtl/instruction_memory_loader.sv
// Byte-stream program loader: length header, LE word assembly, instruction memory writes, core hold.
// Defining IMEM_LOADER_CHECKSUM_EN appends a one-byte XOR checksum check after the payload.
module instruction_memory_loader
    import instruction_memory_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BYTE_WIDTH-1:0] rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WORD_WIDTH-1:0] wr_data,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam int unsigned CAPACITY  = 2 ** ADDR_WIDTH;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam ldr_state_e LDR_FINAL = LDR_CHECK;
`else
    localparam ldr_state_e LDR_FINAL = LDR_DONE;
`endif

    ldr_state_e            state;
    ldr_state_e            state_next;
    ldr_ctl_t              ctl_next;
    logic                  accept_c;
    logic                  clear_c;
    logic                  load_c;
    logic                  word_full_c;
    logic [BYTE_WIDTH-1:0] len_lo;
    logic [LEN_WIDTH-1:0]  len_rx_c;
    logic [CNT_WIDTH-1:0]  len_words;
    logic [CNT_WIDTH-1:0]  words_inc_c;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0] csum;
`endif

    assign accept_c    = rx_valid & rx_ready;
    assign clear_c     = start & ((state == LDR_IDLE) | (state == LDR_DONE) | (state == LDR_ERR));
    assign load_c      = accept_c & (state == LDR_DATA);
    assign len_rx_c    = {rx_data, len_lo};
    assign words_inc_c = words_loaded + CNT_WIDTH'(1);
    assign wr_addr     = words_loaded[ADDR_WIDTH-1:0];

    // State and registered control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LDR_IDLE;
            rx_ready <= 1'b0;
            wr_en    <= 1'b0;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_next;
            rx_ready <= ctl_next.rx_ready;
            wr_en    <= ctl_next.wr_en;
            cpu_hold <= ctl_next.cpu_hold;
            busy     <= ctl_next.busy;
            done     <= ctl_next.done;
            error    <= ctl_next.error;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LDR_IDLE, LDR_DONE, LDR_ERR: if (start) state_next = LDR_LEN_LO;
            LDR_LEN_LO: if (accept_c) state_next = LDR_LEN_HI;
            LDR_LEN_HI: begin
                if (accept_c) begin
                    if (len_rx_c == '0)                         state_next = LDR_FINAL;
                    else if (len_rx_c > LEN_WIDTH'(CAPACITY))   state_next = LDR_ERR;
                    else                                        state_next = LDR_DATA;
                end
            end
            LDR_DATA: if (accept_c && word_full_c) state_next = LDR_WRITE;
            LDR_WRITE: state_next = (words_inc_c < len_words) ? LDR_DATA : LDR_FINAL;
`ifdef IMEM_LOADER_CHECKSUM_EN
            LDR_CHECK: if (accept_c) state_next = (rx_data == csum) ? LDR_DONE : LDR_ERR;
`endif
            default: state_next = LDR_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        ctl_next = ldr_decode(state_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo       <= '0;
            len_words    <= '0;
            words_loaded <= '0;
        end else begin
            if (clear_c)                 words_loaded <= '0;
            else if (state == LDR_WRITE) words_loaded <= words_inc_c;
            if (accept_c && (state == LDR_LEN_LO)) len_lo    <= rx_data;
            if (accept_c && (state == LDR_LEN_HI)) len_words <= CNT_WIDTH'(len_rx_c);
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Running XOR over every payload byte of the session.
    always_ff @(posedge clk) begin
        if (rst || clear_c) csum <= '0;
        else if (load_c)    csum <= csum ^ rx_data;
    end
`endif

    instruction_memory_loader_word_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear_c),
        .load_en     (load_c),
        .byte_in     (rx_data),
        .word        (wr_data),
        .word_full_c (word_full_c)
    );

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Scoreboard bench for instruction_memory_loader: stream-level reference model, write monitor.
module tb_instruction_memory_loader;

    localparam int unsigned AW  = 6;
    localparam int          CAP = 1 << AW;

    typedef logic [7:0] byte_q_t [$];
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    int  n_tests = 0;
    int  n_fail  = 0;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    instruction_memory_loader #(.ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        wr_t e;
        if (wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data %h, no write expected", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 64'(wr_addr), 64'(e.addr));
                check("write_data", 64'(wr_data), 64'(e.data));
            end
        end
    end

    // Reference model: decode the stream and queue the writes a correct loader makes.
    task automatic model(input byte_q_t s, output int consumed, output bit ok, output int nwords);
        int n;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
`endif
        n = int'({s[1], s[0]});
        if (n > CAP) begin
            consumed = 2;
            ok       = 1'b0;
            nwords   = 0;
            return;
        end
        for (int w = 0; w < n; w++) begin
            wr_t e;
            e.addr = AW'(w);
            e.data = {s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]};
            exp_q.push_back(e);
        end
        consumed = 2 + 4 * n;
        nwords   = n;
`ifdef IMEM_LOADER_CHECKSUM_EN
        x = 8'h00;
        for (int i = 2; i < consumed; i++) x ^= s[i];
        ok = (s[consumed] == x);
        consumed++;
`else
        ok = 1'b1;
`endif
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int gap;
        gap      = gaps ? int'($urandom_range(0, 3)) : 0;
        rx_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk); #1;
                rx_valid = 1'b0;
                return;
            end
        end
        n_tests++;
        n_fail++;
        $display("FAIL rx_ready_timeout: byte %h not accepted within 64 cycles", b);
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_session(input byte_q_t s, input bit gaps);
        int consumed;
        int nw;
        bit ok;
        bit seen;
        model(s, consumed, ok, nw);
        pulse_start();
        check("start_cpu_hold", 64'(cpu_hold), 64'(1));
        check("start_busy", 64'(busy), 64'(1));
        check("start_done_cleared", 64'(done), 64'(0));
        check("start_error_cleared", 64'(error), 64'(0));
        for (int i = 0; i < consumed; i++) send_byte(s[i], gaps);
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            seen = done | error;
        end
        check("session_finished", 64'(seen), 64'(1));
        check("done", 64'(done), 64'(ok));
        check("error", 64'(error), 64'(!ok));
        check("end_cpu_hold", 64'(cpu_hold), 64'(!ok));
        check("end_rx_ready", 64'(rx_ready), 64'(0));
        check("end_busy", 64'(busy), 64'(0));
        check("words_loaded", 64'(words_loaded), 64'(nw));
        check("writes_outstanding", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic rand_stream(output byte_q_t s);
        int r;
        int n;
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        s = {};
        r = int'($urandom_range(0, 9));
        if (r == 0)      n = 0;
        else if (r == 1) n = CAP;
        else if (r == 2) n = CAP + 1 + int'($urandom_range(0, 500));
        else             n = int'($urandom_range(1, 8));
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        if (n <= CAP) begin
            for (int i = 0; i < 4 * n; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                s.push_back(b);
`ifdef IMEM_LOADER_CHECKSUM_EN
                x ^= b;
`endif
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            s.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x);
`endif
        end
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        byte_q_t base;
        byte_q_t s;
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) begin @(posedge clk); #1; end

        // Idle after reset
        check("idle_cpu_hold", 64'(cpu_hold), 64'(1));
        check("idle_rx_ready", 64'(rx_ready), 64'(0));
        check("idle_wr_en", 64'(wr_en), 64'(0));
        check("idle_done", 64'(done), 64'(0));
        check("idle_error", 64'(error), 64'(0));
        check("idle_busy", 64'(busy), 64'(0));
        check("idle_words_loaded", 64'(words_loaded), 64'(0));

        base = '{8'h02, 8'h00, 8'h14, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h1A, 8'hA0, 8'hE3};
`ifdef IMEM_LOADER_CHECKSUM_EN
        base.push_back(8'h0F);
`endif
        run_session(base, 1'b0);
        run_session(base, 1'b1);

        // Zero length, over-capacity length, high-byte length
        s = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
        s.push_back(8'h00);
`endif
        run_session(s, 1'b0);
        s = '{8'h41, 8'h00};
        run_session(s, 1'b0);
        s = '{8'h00, 8'h01};
        run_session(s, 1'b0);

        // Full-capacity program
        s = '{8'h40, 8'h00};
        for (int i = 0; i < 4 * CAP; i++) s.push_back(8'($urandom));
`ifdef IMEM_LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 2; i < 2 + 4 * CAP; i++) x ^= s[i];
            s.push_back(x);
        end
`endif
        run_session(s, 1'b1);

        // Reset after six bytes: first word is written, nothing after it
        pulse_start();
        exp_q.push_back(wr_t'{addr: '0, data: 32'hE3A00014});
        for (int i = 0; i < 6; i++) send_byte(base[i], 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst_rx_ready", 64'(rx_ready), 64'(0));
        check("rst_wr_en", 64'(wr_en), 64'(0));
        check("rst_wr_addr", 64'(wr_addr), 64'(0));
        check("rst_wr_data", 64'(wr_data), 64'(0));
        check("rst_cpu_hold", 64'(cpu_hold), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_words_loaded", 64'(words_loaded), 64'(0));
        check("rst_writes_outstanding", 64'(exp_q.size()), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        run_session(base, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        s = base;
        s[s.size()-1] = 8'h0E;
        run_session(s, 1'b0);
`endif

        for (int k = 0; k < 20; k++) begin
            rand_stream(s);
            run_session(s, ($urandom_range(0, 1) == 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
